conv_relu_top: RTL and testbench

Streaming 3x3 convolution + ReLU engine for one 32x32 8-bit grayscale frame per start pulse. It sits between a raster-order pixel source and a downstream feature consumer. Fixed kernel: horizontal-gradient Sobel, rows [1 0 -1], [2 0 -2], [1 0 -1]. It produces 30x30 "valid" (no padding) results in raster order and then signals completion.

---
 rtl/conv_relu_pkg.sv | 49 ++++
 rtl/conv_window_3x3.sv | 71 +++++++
 rtl/conv_relu_top.sv | 94 +++++++++
 tb/tb_conv_relu_top.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_relu_pkg.sv
// Shared geometry, kernel coefficients and FSM encoding for the 3x3 conv + ReLU engine.
package conv_relu_pkg;

    localparam int unsigned IMG_W    = 32;
    localparam int unsigned IMG_H    = 32;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned OUT_W    = 22;
    localparam int unsigned OUT_COLS = IMG_W - 2;
    localparam int unsigned OUT_ROWS = IMG_H - 2;
    localparam int unsigned RESULTS  = OUT_COLS * OUT_ROWS;

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned CNT_W = $clog2(RESULTS + 1);

    // Sum range is -1020..+1020, so 12 signed bits suffice.
    localparam int unsigned SUM_W = 12;

    typedef logic signed [2:0] coef_t;

    // Horizontal-gradient Sobel, row-major, column 0 is the leftmost pixel.
    localparam coef_t KERNEL [3][3] = '{
        '{ 3'sd1, 3'sd0, -3'sd1},
        '{ 3'sd2, 3'sd0, -3'sd2},
        '{ 3'sd1, 3'sd0, -3'sd1}
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // win[row][col]; row 0 is the oldest image row, col 0 the oldest column.
    typedef logic [2:0][2:0][PIX_W-1:0] window_t;

    function automatic logic signed [SUM_W-1:0] conv_sum(input window_t w);
        logic signed [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = acc + $signed({{(SUM_W - PIX_W){1'b0}}, w[i][j]})
                          * SUM_W'(KERNEL[i][j]);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/conv_window_3x3.sv
// Line buffers and 3x3 sliding window; flags the cycle a complete in-frame window is present.
module conv_window_3x3
    import conv_relu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [PIX_W-1:0] pixel,
    output window_t          win,
    output logic             win_valid
);

    logic [PIX_W-1:0] lb1_q [IMG_W];  // row r-1
    logic [PIX_W-1:0] lb2_q [IMG_W];  // row r-2
    window_t          win_q;
    logic             win_valid_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(IMG_W); i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            win_q       <= '0;
            win_valid_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            full_q      <= 1'b0;
        end else if (clear) begin
            win_q       <= '0;
            win_valid_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            full_q      <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            // full_q drops anything past the last pixel of the frame.
            if (accept && !full_q) begin
                lb2_q[col_q] <= lb1_q[col_q];
                lb1_q[col_q] <= pixel;
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb2_q[col_q];
                win_q[1][2] <= lb1_q[col_q];
                win_q[2][2] <= pixel;
                // Rows 0/1 and wrap-straddling columns 0/1 never form a valid window.
                win_valid_q <= (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
                if (col_q == COL_W'(IMG_W - 1)) begin
                    col_q <= '0;
                    if (row_q == ROW_W'(IMG_H - 1)) begin
                        full_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;

endmodule

// File: rtl/conv_relu_top.sv
// Streaming 3x3 Sobel-X convolution with ReLU over one frame per start pulse.
module conv_relu_top
    import conv_relu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_signal,
    input  logic                    pixel_valid,
    input  logic [PIX_W-1:0]        pixel_in,
    output logic signed [OUT_W-1:0] result_out,
    output logic                    result_valid,
    output logic                    done_signal
);

    state_e                  state_q;
    window_t                 win;
    logic                    win_valid;
    logic                    accept;
    logic                    win_clear;
    logic                    keep;
    logic signed [SUM_W-1:0] sum_q;
    logic                    sum_valid_q;
    logic signed [OUT_W-1:0] result_q;
    logic                    result_valid_q;
    logic                    done_q;
    logic [CNT_W-1:0]        res_cnt_q;

    // A start in IDLE or RUN begins a fresh frame; the pixel on that edge is dropped.
    assign win_clear = start_signal && (state_q != StDone);
    assign accept    = (state_q == StRun) && pixel_valid && !start_signal;
    // In-flight work survives only while the current frame is still running.
    assign keep      = (state_q == StRun) && !start_signal;

    conv_window_3x3 u_window (
        .clk       (clk),
        .rst       (rst),
        .clear     (win_clear),
        .accept    (accept),
        .pixel     (pixel_in),
        .win       (win),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            sum_q          <= '0;
            sum_valid_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            res_cnt_q      <= '0;
        end else begin
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;

            sum_q       <= conv_sum(win);
            sum_valid_q <= win_valid && keep;

            if (sum_valid_q && keep) begin
                result_valid_q <= 1'b1;
                result_q       <= sum_q[SUM_W-1] ? '0 : OUT_W'(sum_q);
                res_cnt_q      <= res_cnt_q + 1'b1;
                if (res_cnt_q == CNT_W'(RESULTS - 1)) begin
                    state_q <= StDone;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start_signal) begin
                        state_q   <= StRun;
                        res_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (start_signal) begin
                        res_cnt_q <= '0;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_out   = result_q;
    assign result_valid = result_valid_q;
    assign done_signal  = done_q;

endmodule

// File: tb/tb_conv_relu_top.sv
// Directed frames through conv_relu_top with hand-derived expected column values.
module tb_conv_relu_top;

    localparam int W = 32;
    localparam int H = 32;
    localparam int N_RES = 900;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_signal = 1'b0;
    logic               pixel_valid = 1'b0;
    logic [7:0]         pixel_in = '0;
    logic signed [21:0] result_out;
    logic               result_valid;
    logic               done_signal;

    conv_relu_top dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .result_out   (result_out),
        .result_valid (result_valid),
        .done_signal  (done_signal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int edge_n = 0;
    int exp_edge_q[$];
    int res_q[$];
    int done_cnt = 0;
    int done_edge = 0;
    int last_edge = 0;
    int lat_bad = 0;
    logic track = 1'b0;
    logic cmpl = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pixel patterns: 1 left-dark edge, 2 checkerboard, 3 left-bright edge,
    // 4 descending ramp, 5 ascending ramp.
    function automatic int pix(input int scn, input int x, input int y);
        case (scn)
            1:       return (x < 16) ? 0 : 255;
            2:       return (((x + y) % 2) == 0) ? 255 : 0;
            3:       return (x < 16) ? 255 : 0;
            4:       return 255 - 8 * x;
            default: return 8 * x;
        endcase
    endfunction

    function automatic int exp_val(input int scn, input int oc);
        case (scn)
            3:       return (oc == 14 || oc == 15) ? 1020 : 0;
            4:       return 64;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pixel_valid && track && cmpl) exp_edge_q.push_back(edge_n + 1);
        edge_n <= edge_n + 1;
    end

    always @(negedge clk) begin
        if (result_valid) begin
            res_q.push_back(int'(result_out));
            last_edge = edge_n;
            if (track) begin
                if (exp_edge_q.size() == 0) lat_bad++;
                else if (exp_edge_q.pop_front() != edge_n - 2) lat_bad++;
            end
        end
        if (done_signal) begin
            done_cnt++;
            done_edge = edge_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic trk);
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        res_q.delete();
        exp_edge_q.delete();
        done_cnt = 0;
        lat_bad  = 0;
        track    = trk;
    endtask

    task automatic feed(input int scn, input int gap_pct, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            int x;
            int y;
            x = i % W;
            y = i / W;
            while ($urandom_range(99) < gap_pct) begin
                pixel_valid = 1'b0;
                tick();
            end
            pixel_in    = 8'(pix(scn, x, y));
            cmpl        = (x >= 2) && (y >= 2);
            pixel_valid = 1'b1;
            tick();
            pixel_valid = 1'b0;
            cmpl        = 1'b0;
        end
    endtask

    task automatic full_frame(input string name, input int scn, input int gap_pct);
        int bad;
        int n;
        start_frame(1'b1);
        feed(scn, gap_pct, W * H);
        for (int k = 0; k < 50 && done_cnt == 0; k++) tick();
        repeat (5) tick();
        n = res_q.size();
        bad = 0;
        for (int i = 0; i < n && i < N_RES; i++) begin
            if (res_q[i] != exp_val(scn, i % 30)) bad++;
        end
        check_eq({name, " count"}, n, N_RES);
        check_eq({name, " bad_vals"}, bad, 0);
        check_eq({name, " done_pulses"}, done_cnt, 1);
        check_eq({name, " done_gap"}, done_edge - last_edge, 1);
        check_eq({name, " latency_bad"}, lat_bad + exp_edge_q.size(), 0);
        track = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int snap;
        repeat (3) tick();
        check_eq("reset result_valid", int'(result_valid), 0);
        check_eq("reset done_signal", int'(done_signal), 0);
        check_eq("reset result_out", int'(result_out), 0);
        rst = 1'b0;
        tick();

        // Pixels while idle must not produce anything.
        pixel_valid = 1'b1;
        pixel_in    = 8'd200;
        repeat (40) tick();
        pixel_valid = 1'b0;
        repeat (4) tick();
        check_eq("idle no results", res_q.size(), 0);

        full_frame("edge_lr", 1, 0);
        full_frame("checker", 2, 0);
        full_frame("edge_inv", 3, 0);
        check_eq("edge_inv col14", res_q[14], 1020);
        check_eq("edge_inv col15", res_q[15], 1020);
        check_eq("edge_inv col13", res_q[13], 0);
        check_eq("edge_inv r29c16", res_q[899 - 13], 0);
        full_frame("ramp_down", 4, 0);
        full_frame("ramp_up", 5, 0);
        full_frame("edge_gaps", 3, 30);
        check_eq("edge_gaps r5c15", res_q[5 * 30 + 15], 1020);

        // Reset mid-frame after 500 pixels.
        start_frame(1'b0);
        feed(3, 0, 500);
        rst = 1'b1;
        tick();
        snap = res_q.size();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check_eq("abort no_more_results", res_q.size(), snap);
        check_eq("abort no_done", done_cnt, 0);
        full_frame("after_abort", 3, 0);

        // Restart while running: partial frame is discarded.
        start_frame(1'b0);
        feed(1, 0, 300);
        full_frame("restart", 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
